// File: rtl/mls_dac_mapper.sv
// Maps the MLS generator bit stream to saturated offset +/- amplitude DAC codes,
// sequences the generator (reseed, enable, burst count) and streams codes via a small FIFO.
module mls_dac_mapper #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        srst,
   input  logic        start_i,
   input  logic        stop_i,
   input  logic [13:0] amp_i,
   input  logic [13:0] offset_i,
   input  logic        invert_i,
   input  logic [7:0]  burst_i,
   input  logic        sig_i,
   input  logic        flag_i,
   output logic        en_o,
   output logic        lfsr_srst_o,
   output logic [15:0] m_axis_tdata,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic        m_axis_tlast,
   output logic        busy_o,
   output logic        done_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, SEED, RUN, DRAIN} state_t;

   state_t state, state_next;

   logic [13:0] amp_q;
   logic [13:0] offset_q;
   logic        invert_q;
   logic [7:0]  burst_q;
   logic [7:0]  seq_cnt;
   logic [7:0]  seq_inc;
   logic        stop_pending;

   logic [16:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          full, push, pop;
   logic          flag_cap, seq_end;

   logic signed [15:0] amp_ext, off_ext, sum, code;

   // en_o comes straight from the registered count, so a full FIFO never takes a write
   // even when a pop happens in the same cycle.
   assign full    = (count == DEPTH_C);
   assign push    = (state == RUN) && !full;
   assign pop     = m_axis_tvalid && m_axis_tready;
   assign en_o    = push;
   assign busy_o  = (state != IDLE);

   assign seq_inc  = seq_cnt + 8'd1;
   assign flag_cap = push && flag_i;
   assign seq_end  = flag_cap && (((burst_q != 8'd0) && (seq_inc == burst_q)) || stop_pending);

   always_comb begin
      amp_ext = signed'({2'b00, amp_q});
      off_ext = signed'({{2{offset_q[13]}}, offset_q});
      sum     = (sig_i ^ invert_q) ? off_ext + amp_ext : off_ext - amp_ext;
      if (sum > 16'sd8191)
         code = 16'sd8191;
      else if (sum < -16'sd8192)
         code = -16'sd8192;
      else
         code = sum;
   end

   always_ff @(posedge clk) begin
      if (srst)
         state <= IDLE;
      else
         state <= state_next;
   end

   // NOTE: every output of this block gets a default before the case, so no path infers a latch.
   always_comb begin
      state_next  = state;
      lfsr_srst_o = 1'b0;
      done_o      = 1'b0;
      case (state)
         IDLE:  if (start_i) state_next = SEED;
         SEED: begin
            lfsr_srst_o = 1'b1;
            state_next  = RUN;
         end
         RUN:   if (seq_end) state_next = DRAIN;
         DRAIN: begin
            if (count == '0) begin
               done_o     = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         amp_q        <= '0;
         offset_q     <= '0;
         invert_q     <= 1'b0;
         burst_q      <= '0;
         seq_cnt      <= '0;
         stop_pending <= 1'b0;
      end else if (state == IDLE && start_i) begin
         amp_q        <= amp_i;
         offset_q     <= offset_i;
         invert_q     <= invert_i;
         burst_q      <= burst_i;
         seq_cnt      <= '0;
         stop_pending <= 1'b0;
      end else begin
         if (flag_cap)
            seq_cnt <= seq_inc;
         if ((state == SEED || state == RUN) && stop_i)
            stop_pending <= 1'b1;
      end
   end

   // NOTE: the storage array has no reset; validity is tracked by count alone, and
   // m_axis_tdata is gated by tvalid so nothing stale leaks out after reset.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= {flag_i, code};
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign m_axis_tvalid = (count != '0);
   assign m_axis_tdata  = m_axis_tvalid ? mem[rd_ptr][15:0] : 16'd0;
   assign m_axis_tlast  = m_axis_tvalid && mem[rd_ptr][16];

endmodule

// File: tb/tb_mls_dac_mapper.sv
// Scoreboard bench for mls_dac_mapper: a 7-bit MLS generator model drives the DUT and
// expected codes come from plain integer arithmetic on the mapping rules.
module tb_mls_dac_mapper;

   localparam int DEPTH  = 4;
   localparam int PERIOD = 7;

   logic        clk = 1'b0;
   logic        srst;
   logic        start_i, stop_i, invert_i;
   logic [13:0] amp_i, offset_i;
   logic [7:0]  burst_i;
   logic        sig_i, flag_i;
   logic        en_o, lfsr_srst_o;
   logic [15:0] m_axis_tdata;
   logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
   logic        busy_o, done_o;

   mls_dac_mapper #(.FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .srst(srst), .start_i(start_i), .stop_i(stop_i),
      .amp_i(amp_i), .offset_i(offset_i), .invert_i(invert_i), .burst_i(burst_i),
      .sig_i(sig_i), .flag_i(flag_i), .en_o(en_o), .lfsr_srst_o(lfsr_srst_o),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
      .busy_o(busy_o), .done_o(done_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   logic [16:0] exp_q [$];
   int done_cnt = 0, seed_cnt = 0, beats = 0, cap_cnt = 0;
   int gen_seq = 0, gen_idx = 0;
   int rdy_mode = 0;
   bit pat [PERIOD] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [16:0] model(input bit b, input logic [13:0] amp, input logic [13:0] off,
                                         input bit inv, input bit last);
      int v;
      v = int'($signed(off)) + (((b ^ inv) != 1'b0) ? int'(amp) : -int'(amp));
      if (v > 8191)  v = 8191;
      if (v < -8192) v = -8192;
      return {last, v[15:0]};
   endfunction

   task automatic push_expected(input logic [13:0] amp, input logic [13:0] off, input bit inv, input int nseq);
      for (int i = 0; i < nseq * PERIOD; i++)
         exp_q.push_back(model(pat[i % PERIOD], amp, off, inv, (i % PERIOD) == PERIOD - 1));
   endtask

   // Parameters are scrambled right after the start pulse: the DUT must use its latched copies.
   task automatic start_run(input logic [13:0] amp, input logic [13:0] off, input bit inv, input logic [7:0] burst);
      amp_i = amp; offset_i = off; invert_i = inv; burst_i = burst;
      start_i = 1'b1;
      step();
      start_i  = 1'b0;
      amp_i    = 14'($urandom);
      offset_i = 14'($urandom);
      invert_i = ~inv;
      burst_i  = 8'($urandom);
   endtask

   task automatic wait_done(input string name, input int seeds0);
      int d0 = done_cnt;
      int n = 0;
      while (done_cnt == d0 && n < 4000) begin
         step();
         n++;
      end
      check({name, "_done_seen"}, done_cnt - d0, 1);
      check({name, "_idle_after_done"}, busy_o, 0);
      check({name, "_sb_empty"}, exp_q.size(), 0);
      check({name, "_one_reseed"}, seed_cnt - seeds0, 1);
      exp_q.delete();
   endtask

   // Generator model: reseeds to index 0, advances one bit per enabled cycle.
   initial begin
      bit s, a;
      sig_i  = pat[0];
      flag_i = 1'b0;
      forever begin
         @(negedge clk);
         s = lfsr_srst_o;
         a = en_o;
         @(posedge clk);
         #1;
         if (s) begin
            gen_idx = 0;
            gen_seq = 0;
         end else if (a) begin
            cap_cnt++;
            if (gen_idx == PERIOD - 1) gen_seq++;
            gen_idx = (gen_idx + 1) % PERIOD;
         end
         sig_i  = pat[gen_idx];
         flag_i = (gen_idx == PERIOD - 1);
      end
   end

   initial begin
      m_axis_tready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = ($urandom_range(0, 3) != 0);
            default: m_axis_tready = 1'b0;
         endcase
      end
   end

   // Monitor: pops the scoreboard on every handshake and checks AXI hold rules.
   initial begin
      logic [16:0] e;
      logic [15:0] hold_data;
      logic        hold_last;
      bit          stall_prev, done_prev;
      stall_prev = 1'b0;
      done_prev  = 1'b0;
      hold_data  = '0;
      hold_last  = 1'b0;
      forever begin
         @(negedge clk);
         if (done_o) begin
            done_cnt++;
            check("done_one_cycle", done_prev, 0);
         end
         done_prev = done_o;
         if (lfsr_srst_o) seed_cnt++;
         if (!srst && stall_prev) begin
            check("stall_tvalid_held", m_axis_tvalid, 1);
            check("stall_tdata_held", m_axis_tdata, hold_data);
            check("stall_tlast_held", m_axis_tlast, hold_last);
         end
         stall_prev = !srst && m_axis_tvalid && !m_axis_tready;
         hold_data  = m_axis_tdata;
         hold_last  = m_axis_tlast;
         if (!srst && m_axis_tvalid && m_axis_tready) begin
            beats++;
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_beat: got tdata=0x%0h tlast=%0b, expected no beat (t=%0t)",
                        m_axis_tdata, m_axis_tlast, $time);
            end else begin
               e = exp_q.pop_front();
               check("beat_tdata", m_axis_tdata, e[15:0]);
               check("beat_tlast", m_axis_tlast, e[16]);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running at t=%0t, expected completion", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int s0, b0, c0, d0, n, nseq;
      logic [13:0] ra, ro;
      bit ri;

      srst = 1'b1; start_i = 1'b0; stop_i = 1'b0; invert_i = 1'b0;
      amp_i = '0; offset_i = '0; burst_i = '0;
      step();
      step();
      check("reset_en", en_o, 0);
      check("reset_lfsr_srst", lfsr_srst_o, 0);
      check("reset_tvalid", m_axis_tvalid, 0);
      check("reset_tlast", m_axis_tlast, 0);
      check("reset_tdata", m_axis_tdata, 0);
      check("reset_busy", busy_o, 0);
      check("reset_done", done_o, 0);
      srst = 1'b0;
      step();

      // Mapping and saturation, both polarities
      rdy_mode = 0;
      step();
      for (int inv = 0; inv < 2; inv++) begin
         s0 = seed_cnt;
         push_expected(14'd5000, 14'd4000, inv[0], 1);
         start_run(14'd5000, 14'd4000, inv[0], 8'd1);
         wait_done("map", s0);
      end

      // Two-sequence burst
      s0 = seed_cnt; b0 = beats;
      push_expected(14'd1000, 14'(-200), 1'b0, 2);
      start_run(14'd1000, 14'(-200), 1'b0, 8'd2);
      wait_done("burst", s0);
      check("burst_beats", beats - b0, 14);

      // Back-pressure mid-burst
      s0 = seed_cnt; b0 = beats;
      push_expected(14'd2100, 14'(-3000), 1'b1, 2);
      start_run(14'd2100, 14'(-3000), 1'b1, 8'd2);
      n = 0;
      while (beats - b0 < 5 && n < 200) begin
         @(negedge clk);
         n++;
      end
      rdy_mode = 2;
      c0 = cap_cnt;
      repeat (11) step();
      check("bp_en_low", en_o, 0);
      check("bp_tvalid_held", m_axis_tvalid, 1);
      check("bp_captures_le_depth", (cap_cnt - c0) <= DEPTH, 1);
      rdy_mode = 0;
      wait_done("bp", s0);
      check("bp_beats", beats - b0, 14);

      // Continuous mode stopped on bit 3 of sequence 2
      s0 = seed_cnt; b0 = beats;
      push_expected(14'd777, 14'd100, 1'b0, 2);
      start_run(14'd777, 14'd100, 1'b0, 8'd0);
      n = 0;
      while (!(gen_seq == 1 && gen_idx == 3) && n < 200) begin
         @(negedge clk);
         n++;
      end
      stop_i = 1'b1;
      @(negedge clk);
      stop_i = 1'b0;
      wait_done("stop", s0);
      check("stop_beats", beats - b0, 14);

      // start_i during RUN and in the done cycle
      s0 = seed_cnt; b0 = beats; d0 = done_cnt;
      push_expected(14'd3000, 14'(-5000), 1'b0, 2);
      start_run(14'd3000, 14'(-5000), 1'b0, 8'd2);
      n = 0;
      while (beats - b0 < 9 && n < 200) begin
         @(negedge clk);
         n++;
      end
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      n = 0;
      while (!done_o && n < 400) begin
         @(negedge clk);
         n++;
      end
      start_i = 1'b1;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      check("start_in_done_ignored", busy_o, 0);
      repeat (3) step();
      check("start_ignored_busy", busy_o, 0);
      check("start_ignored_reseeds", seed_cnt - s0, 1);
      check("start_ignored_beats", beats - b0, 14);
      check("start_ignored_done", done_cnt - d0, 1);
      check("start_ignored_sb_empty", exp_q.size(), 0);
      exp_q.delete();

      // Reset mid-RUN with three codes buffered and tready low
      rdy_mode = 2;
      step();
      start_run(14'd300, 14'd0, 1'b0, 8'd0);
      step();
      repeat (3) step();
      d0 = done_cnt;
      srst = 1'b1;
      step();
      check("midrst_tvalid", m_axis_tvalid, 0);
      check("midrst_en", en_o, 0);
      step();
      step();
      srst = 1'b0;
      step();
      check("midrst_busy", busy_o, 0);
      check("midrst_no_done", done_cnt - d0, 0);

      // Randomized bursts under random back-pressure
      rdy_mode = 1;
      for (int k = 0; k < 5; k++) begin
         ra   = 14'($urandom);
         ro   = 14'($urandom);
         ri   = 1'($urandom);
         nseq = $urandom_range(1, 3);
         s0 = seed_cnt; b0 = beats;
         push_expected(ra, ro, ri, nseq);
         start_run(ra, ro, ri, 8'(nseq));
         wait_done("rand", s0);
         check("rand_beats", beats - b0, nseq * PERIOD);
      end

      rdy_mode = 0;
      repeat (2) step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
